// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: reset vector, flush word, opcode and
// funct encodings, and the next-PC target arithmetic used by fetch and decode.
package mips_pkg;

    // Architectural constants
    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;   // sll $0,$0,0
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Which control transfer (if any) steers the next PC
    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_BEQ,
        REDIR_J,
        REDIR_JR
    } redir_src_e;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    // PC-relative branch target: pc4 + sign-extended word offset
    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm16);
        return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    // Pseudo-direct jump target within the current 256 MB region
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

    // Redirect arbitration: jr beats j beats taken beq, only for a real instruction
    function automatic redir_src_e redirect_source(input logic valid,
                                                   input logic jr,
                                                   input logic j,
                                                   input logic beq_taken);
        if (!valid)         return REDIR_NONE;
        else if (jr)        return REDIR_JR;
        else if (j)         return REDIR_J;
        else if (beq_taken) return REDIR_BEQ;
        else                return REDIR_NONE;
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection for the fetch stage: sequential PC+4 or a redirect target
// resolved in ID (beq taken, j/jal, jr). Purely combinational.
module npc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] if_id_pc4,
    input  logic [25:0] if_id_index,
    input  logic        if_id_valid,
    input  logic        id_beq_taken,
    input  logic        id_j,
    input  logic        id_jr,
    input  logic [31:0] id_rs_data,
    output logic [31:0] next_pc,
    output logic        redirect
);
    import mips_pkg::*;

    redir_src_e  w_src;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_seq_pc;

    assign w_src        = redirect_source(if_id_valid, id_jr, id_j, id_beq_taken);
    assign w_branch_tgt = branch_target(if_id_pc4, if_id_index[15:0]);
    assign w_jump_tgt   = jump_target(if_id_pc4[31:28], if_id_index);
    assign w_seq_pc     = pc + PC_STEP;

    // Pick the next PC from the winning redirect source, else fall through
    always_comb begin
        next_pc  = w_seq_pc;
        redirect = 1'b0;
        case (w_src)
            REDIR_JR: begin
                next_pc  = id_rs_data;
                redirect = 1'b1;
            end
            REDIR_J: begin
                next_pc  = w_jump_tgt;
                redirect = 1'b1;
            end
            REDIR_BEQ: begin
                next_pc  = w_branch_tgt;
                redirect = 1'b1;
            end
            default: begin
                next_pc  = w_seq_pc;
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: holds the PC, addresses instruction memory,
// latches the fetched word with its PC+4, exposes decode fields, and counts
// accepted instructions. Redirects squash the wrong-path fetch (one bubble).
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        id_beq_taken,
    input  logic        id_j,
    input  logic        id_jr,
    input  logic [31:0] id_rs_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [31:0] fetch_count
);
    import mips_pkg::*;

    logic [31:0] r_pc;
    if_id_t      r_if_id;
    logic [31:0] r_count;

    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + PC_STEP;

    npc_calc u_npc_calc (
        .pc           (r_pc),
        .if_id_pc4    (r_if_id.pc4),
        .if_id_index  (r_if_id.instr[25:0]),
        .if_id_valid  (r_if_id.valid),
        .id_beq_taken (id_beq_taken),
        .id_j         (id_j),
        .id_jr        (id_jr),
        .id_rs_data   (id_rs_data),
        .next_pc      (w_next_pc),
        .redirect     (w_redirect)
    );

    // PC register: redirect beats stall; otherwise step sequentially
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (w_redirect || !stall) begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID register: flush to a bubble on redirect, hold on stall, else load fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id.instr <= NOP_INSTR;
            r_if_id.pc4   <= '0;
            r_if_id.valid <= 1'b0;
        end else if (w_redirect) begin
            r_if_id.instr <= NOP_INSTR;
            r_if_id.pc4   <= '0;
            r_if_id.valid <= 1'b0;
        end else if (!stall) begin
            r_if_id.instr <= imem_rdata;
            r_if_id.pc4   <= w_pc_plus4;
            r_if_id.valid <= 1'b1;
        end
    end

    // Fetch counter: advances only when a fetched word enters IF/ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!w_redirect && !stall) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_instr = r_if_id.instr;
    assign if_id_pc4   = r_if_id.pc4;
    assign if_id_valid = r_if_id.valid;
    assign fetch_count = r_count;

    assign op    = r_if_id.instr[31:26];
    assign rs    = r_if_id.instr[25:21];
    assign rt    = r_if_id.instr[20:16];
    assign rd    = r_if_id.instr[15:11];
    assign imm16 = r_if_id.instr[15:0];
    assign func  = r_if_id.instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// stall/redirect traffic, all checked against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        id_beq_taken;
    logic        id_j;
    logic        id_jr;
    logic [31:0] id_rs_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (32'h0000_3000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .id_beq_taken (id_beq_taken),
        .id_j         (id_j),
        .id_jr        (id_jr),
        .id_rs_data   (id_rs_data),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .op           (op),
        .func         (func),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm16        (imm16),
        .fetch_count  (fetch_count)
    );

    // Combinational instruction memory, 256 words aliased over the address space
    logic [31:0] mem [256];
    assign imem_rdata = mem[imem_addr[9:2]];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endtask

    // One clock edge of the fetch stage, from the behavioural rules
    task automatic model_edge(input logic st, input logic beq, input logic j,
                              input logic jr, input logic [31:0] rsd);
        logic [31:0] fetched;
        logic [31:0] tgt;
        int          off;
        fetched = mem[m_pc[9:2]];
        if (m_valid && (jr || j || beq)) begin
            if (jr) begin
                tgt = rsd;
            end else if (j) begin
                tgt = (m_pc4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
            end else begin
                off = $signed(m_instr[15:0]);
                tgt = m_pc4 + 32'(off * 4);
            end
            m_pc    = tgt;
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (!st) begin
            m_instr = fetched;
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".pc"},    imem_addr,   m_pc);
        check({ctx, ".instr"}, if_id_instr, m_instr);
        check({ctx, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({ctx, ".count"}, fetch_count, m_cnt);
        if (m_valid) check({ctx, ".pc4"}, if_id_pc4, m_pc4);
        check({ctx, ".op"},    {26'd0, op},    m_instr >> 26);
        check({ctx, ".rs"},    {27'd0, rs},    (m_instr >> 21) & 32'h1F);
        check({ctx, ".rt"},    {27'd0, rt},    (m_instr >> 16) & 32'h1F);
        check({ctx, ".rd"},    {27'd0, rd},    (m_instr >> 11) & 32'h1F);
        check({ctx, ".imm"},   {16'd0, imm16}, m_instr & 32'hFFFF);
        check({ctx, ".func"},  {26'd0, func},  m_instr & 32'h3F);
    endtask

    // Called at a falling edge: drive inputs, advance model, check after next edge
    task automatic step(input logic st, input logic beq, input logic j, input logic jr,
                        input logic [31:0] rsd, input string ctx);
        stall        = st;
        id_beq_taken = beq;
        id_j         = j;
        id_jr        = jr;
        id_rs_data   = rsd;
        model_edge(st, beq, j, jr, rsd);
        @(posedge clk);
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic async_reset(input string ctx);
        #2 rst_n = 1'b0;
        stall = 1'b0; id_beq_taken = 1'b0; id_j = 1'b0; id_jr = 1'b0;
        #1;
        model_reset();
        check_all(ctx);
        check({ctx, ".pc_const"}, imem_addr, 32'h0000_3000);
        check({ctx, ".pc4"},      if_id_pc4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, {ctx, ".first"});
        check({ctx, ".first_pc4"},   if_id_pc4, 32'h0000_3004);
        check({ctx, ".first_valid"}, {31'd0, if_id_valid}, 32'd1);
    endtask

    logic [31:0] saved_instr;
    logic [31:0] saved_cnt;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; id_beq_taken = 1'b0; id_j = 1'b0; id_jr = 1'b0;
        id_rs_data = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h03] = {6'h04, 5'd1, 5'd2, 16'hFFFE};     // 0x300C: beq back to 0x3008
        mem[8'h04] = {6'h02, 26'h000_0C10};             // 0x3010: j 0x3040
        mem[8'h10] = {6'h00, 5'd31, 15'd0, 6'h08};      // 0x3040: jr $31
        mem[8'h40] = {6'h04, 5'd3, 5'd3, 16'h0004};     // 0x3100: beq +4 words
        model_reset();

        repeat (2) @(negedge clk);
        check_all("reset");
        check("reset.pc4", if_id_pc4, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch
        step(0, 0, 0, 0, 0, "seq1");
        check("seq1.pc4", if_id_pc4, 32'h0000_3004);
        step(0, 0, 0, 0, 0, "seq2");
        step(0, 0, 0, 0, 0, "seq3");
        check("seq3.pc4",   if_id_pc4,   32'h0000_300C);
        check("seq3.count", fetch_count, 32'd3);

        // Stall holds everything
        saved_instr = if_id_instr;
        step(1, 0, 0, 0, 0, "stall1");
        step(1, 0, 0, 0, 0, "stall2");
        check("stall.pc",    imem_addr,   32'h0000_300C);
        check("stall.instr", if_id_instr, mem[8'h02]);
        check("stall.count", fetch_count, 32'd3);
        step(0, 0, 0, 0, 0, "resume");
        check("resume.pc4", if_id_pc4, 32'h0000_3010);

        // Taken beq with negative offset
        step(0, 1, 0, 0, 0, "beq");
        check("beq.pc",    imem_addr,   32'h0000_3008);
        check("beq.instr", if_id_instr, 32'h0);
        check("beq.count", fetch_count, 32'd4);

        // j then jr (jr wins over j)
        step(0, 0, 0, 0, 0, "walk1");
        step(0, 0, 0, 0, 0, "walk2");
        step(0, 0, 0, 0, 0, "walk3");
        step(0, 0, 1, 0, 0, "j");
        check("j.pc", imem_addr, 32'h0000_3040);
        step(0, 0, 0, 0, 0, "fetch_jr");
        step(0, 0, 1, 1, 32'h0000_3100, "jr");
        check("jr.pc", imem_addr, 32'h0000_3100);

        // Redirect overlapping stall: redirect wins
        step(0, 0, 0, 0, 0, "fetch_beq2");
        saved_cnt = fetch_count;
        $display("warning: redirect asserted together with stall (intentional)");
        step(1, 1, 0, 0, 0, "beq_stall");
        check("beq_stall.pc",    imem_addr,   32'h0000_3114);
        check("beq_stall.count", fetch_count, saved_cnt);
        check("beq_stall.valid", {31'd0, if_id_valid}, 32'd0);

        // PC wrap at the top of the address space
        step(0, 0, 0, 0, 0, "fetch_pre_wrap");
        step(0, 0, 0, 1, 32'hFFFF_FFFC, "jr_top");
        step(0, 0, 0, 0, 0, "wrap");
        check("wrap.pc",  imem_addr, 32'h0);
        check("wrap.pc4", if_id_pc4, 32'h0);

        // Randomized traffic with a reset in the middle
        for (int n = 0; n < 400; n++) begin
            if (n == 200) async_reset("midrst");
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom,
                 "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
